// File: rtl/io_bus_arbiter_if.sv
// Requester A/B handshakes plus the IO port block bus, grouped for the arbiter.
// The slave modport is the arbiter side; the master modport is the requesters and IO block side.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_wdata;
    logic              a_ack;
    logic [7:0]        a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_wdata;
    logic              b_ack;
    logic [7:0]        b_rdata;
    logic              b_err;

    logic [ADDR_W-1:0] io_addr;
    logic              io_re;
    logic              io_we;
    logic [7:0]        io_din;
    logic [7:0]        io_dout;
    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output io_addr, io_re, io_we, io_din,
        input  io_dout,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  io_addr, io_re, io_we, io_din,
        output io_dout,
        input  busy
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin two-master arbiter driving the IO port bus (setup/strobe/ack); IO_ADDR_CHECK_EN adds address>7 error acks.
// Latency: req sampled in IDLE -> ack STROBE_CYCLES+2 cycles later; backpressure: requesters hold req until their ack.
module io_bus_arbiter #(
    parameter int STROBE_CYCLES = 1,
    parameter int ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    io_bus_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;
    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    typedef struct packed {
        logic b_sel;
        logic we;
    } xfer_t;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_b_q, last_b_d;
    xfer_t             xfer_q, xfer_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [7:0]        io_din_q, io_din_d;
    logic              io_re_q, io_re_d;
    logic              io_we_q, io_we_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic [7:0]        a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;

    logic              grant_vld;
    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;
    logic              addr_bad;

    // On a tie the requester not served last wins; last_b_q=1 means B was served last.
    always_comb begin
        grant_vld = bus.a_req | bus.b_req;
        grant_b   = (bus.a_req && bus.b_req) ? ~last_b_q : bus.b_req;
        sel_we    = grant_b ? bus.b_we    : bus.a_we;
        sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
    end

`ifdef IO_ADDR_CHECK_EN
    assign addr_bad = (sel_addr > ADDR_W'(7));
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        xfer_d    = xfer_q;
        io_addr_d = io_addr_q;
        io_din_d  = io_din_q;
        io_re_d   = 1'b0;
        io_we_d   = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    xfer_d.b_sel = grant_b;
                    xfer_d.we    = sel_we;
                    last_b_d     = grant_b;
                    if (addr_bad) begin
                        state_d = S_ACK;
                        a_ack_d = ~grant_b;
                        b_ack_d = grant_b;
                        a_err_d = ~grant_b;
                        b_err_d = grant_b;
                    end else begin
                        state_d   = S_SETUP;
                        io_addr_d = sel_addr;
                        io_din_d  = sel_we ? sel_wdata : 8'h00;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_LOAD;
                io_re_d = ~xfer_q.we;
                io_we_d = xfer_q.we;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    a_ack_d = ~xfer_q.b_sel;
                    b_ack_d = xfer_q.b_sel;
                    if (!xfer_q.we) begin
                        if (xfer_q.b_sel) b_rdata_d = bus.io_dout;
                        else              a_rdata_d = bus.io_dout;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    io_re_d = ~xfer_q.we;
                    io_we_d = xfer_q.we;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            last_b_q  <= 1'b1;
            xfer_q    <= '0;
            io_addr_q <= '0;
            io_din_q  <= 8'h00;
            io_re_q   <= 1'b0;
            io_we_q   <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            xfer_q    <= xfer_d;
            io_addr_q <= io_addr_d;
            io_din_q  <= io_din_d;
            io_re_q   <= io_re_d;
            io_we_q   <= io_we_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.io_addr = io_addr_q;
    assign bus.io_din  = io_din_q;
    assign bus.io_re   = io_re_q;
    assign bus.io_we   = io_we_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.a_err   = a_err_q;
    assign bus.b_err   = b_err_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.busy    = busy_q;
endmodule
